// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate-generation stage:
// format codes, RV32IM opcodes and the decoded field bundle.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } fmt_e;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  // The immediate travels beside this bundle because
  // its width follows XLEN.
  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
  } dec_bundle_t;

  function automatic fmt_e opc_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_LUI, OPC_AUIPC:  f = FMT_U;
      OPC_JAL:             f = FMT_J;
      OPC_JALR, OPC_LOAD,
      OPC_OPIMM,
      OPC_SYSTEM,
      OPC_MISCMEM:         f = FMT_I;
      OPC_STORE:           f = FMT_S;
      OPC_BRANCH:          f = FMT_B;
      OPC_OP:              f = FMT_R;
      default:             f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational field split and immediate build.
// Ports: ins_i raw word; dec_o fields; imm_o sign-extended imm.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins_i,
  output dec_bundle_t     dec_o,
  output logic [XLEN-1:0] imm_o
);

  fmt_e        fmt;
  logic [31:0] imm32;

  assign fmt = opc_fmt(ins_i[6:0]);

  always_comb begin
    dec_o         = '0;
    dec_o.fmt     = fmt;
    dec_o.opcode  = ins_i[6:0];
    dec_o.rd      = ins_i[11:7];
    dec_o.rs1     = ins_i[19:15];
    dec_o.rs2     = ins_i[24:20];
    dec_o.funct3  = ins_i[14:12];
    dec_o.funct7  = ins_i[31:25];
    dec_o.illegal = (fmt == FMT_NONE);
  end

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      (fmt == FMT_I):
        imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
      (fmt == FMT_S):
        imm32 = {{20{ins_i[31]}}, ins_i[31:25],
                 ins_i[11:7]};
      (fmt == FMT_B):
        imm32 = {{19{ins_i[31]}}, ins_i[31], ins_i[7],
                 ins_i[30:25], ins_i[11:8], 1'b0};
      (fmt == FMT_U):
        imm32 = {ins_i[31:12], 12'b0};
      (fmt == FMT_J):
        imm32 = {{11{ins_i[31]}}, ins_i[31],
                 ins_i[19:12], ins_i[20],
                 ins_i[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Bit 31 of every 32-bit immediate already carries
  // the sign, so wider XLEN just replicates it.
  generate
    if (XLEN > 32) begin : g_ext
      assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_noext
      assign imm_o = imm32;
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered valid/ready immediate-generation stage.
// Ports: in_* handshake + word; out_* handshake + decoded fields.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_illegal
);

  dec_bundle_t     dec_in;
  logic [XLEN-1:0] imm_in;

  dec_bundle_t     out_q, out_d;
  dec_bundle_t     skid_q, skid_d;
  logic [XLEN-1:0] oimm_q, oimm_d;
  logic [XLEN-1:0] simm_q, simm_d;
  logic            ovld_q, ovld_d;
  logic            svld_q, svld_d;

  logic in_fire;
  logic load_out;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .ins_i (in_ins),
    .dec_o (dec_in),
    .imm_o (imm_in)
  );

  // With the skid entry, ready depends only on state,
  // breaking the out_ready -> in_ready path.
  assign load_out = !ovld_q || out_ready;
  assign in_ready = (SKID != 0) ? !svld_q : load_out;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    out_d  = out_q;
    oimm_d = oimm_q;
    ovld_d = ovld_q;
    skid_d = skid_q;
    simm_d = simm_q;
    svld_d = svld_q;
    if (load_out) begin
      // A held skid word always drains first; in_ready
      // is low then, so no input competes with it.
      if (svld_q) begin
        out_d  = skid_q;
        oimm_d = simm_q;
        ovld_d = 1'b1;
        svld_d = 1'b0;
      end else if (in_fire) begin
        out_d  = dec_in;
        oimm_d = imm_in;
        ovld_d = 1'b1;
      end else begin
        ovld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d = dec_in;
      simm_d = imm_in;
      svld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      oimm_q <= '0;
      ovld_q <= 1'b0;
      skid_q <= '0;
      simm_q <= '0;
      svld_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      oimm_q <= oimm_d;
      ovld_q <= ovld_d;
      skid_q <= skid_d;
      simm_q <= simm_d;
      svld_q <= svld_d;
    end
  end

  assign out_valid   = ovld_q;
  assign out_imm     = oimm_q;
  assign out_fmt     = out_q.fmt;
  assign out_opcode  = out_q.opcode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (SKID=1, XLEN=64
// and SKID=0 copies share the input stimulus).
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_ins;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt, a_f3;
  logic [6:0]  a_opc, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2;

  logic        w_in_ready, w_out_valid, w_illegal;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt, w_f3;
  logic [6:0]  w_opc, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;

  logic        z_in_ready, z_out_valid, z_illegal;
  logic [31:0] z_imm;
  logic [2:0]  z_fmt, z_f3;
  logic [6:0]  z_opc, z_f7;
  logic [4:0]  z_rd, z_rs1, z_rs2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ins(in_ins),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt),
    .out_opcode(a_opc), .out_rd(a_rd),
    .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_funct7(a_f7),
    .out_illegal(a_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .SKID(1)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_ins(in_ins),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_imm(w_imm), .out_fmt(w_fmt),
    .out_opcode(w_opc), .out_rd(w_rd),
    .out_rs1(w_rs1), .out_rs2(w_rs2),
    .out_funct3(w_f3), .out_funct7(w_f7),
    .out_illegal(w_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(z_in_ready),
    .in_ins(in_ins),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .out_imm(z_imm), .out_fmt(z_fmt),
    .out_opcode(z_opc), .out_rd(z_rd),
    .out_rs1(z_rs1), .out_rs2(z_rs2),
    .out_funct3(z_f3), .out_funct7(z_f7),
    .out_illegal(z_illegal)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0;
    out_ready = 1'b0; in_ins = '0;
    tick; tick;
    checks++;
    if (a_out_valid !== 1'b0)
      $display("FAIL rst_valid got %b exp 0", a_out_valid);
    else passes++;
    checks++;
    if (a_imm !== 32'h0 || a_rd !== 5'd0 || a_fmt !== 3'd0)
      $display("FAIL rst_data got imm %h rd %0d fmt %0d exp 0",
               a_imm, a_rd, a_fmt);
    else passes++;
    rst = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || z_in_ready !== 1'b1)
      $display("FAIL rst_ready got %b/%b exp 1/1",
               a_in_ready, z_in_ready);
    else passes++;
    tick;
    checks++;
    if (a_out_valid !== 1'b0)
      $display("FAIL idle_valid got %b exp 0", a_out_valid);
    else passes++;
  endtask

  task automatic test_jal;
    out_ready = 1'b1; in_valid = 1'b1;
    in_ins = 32'hFFDFF06F;
    tick;
    in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_fmt !== FMT_J)
      $display("FAIL jal_vf got v %b fmt %0d exp 1 %0d",
               a_out_valid, a_fmt, FMT_J);
    else passes++;
    checks++;
    if (a_imm !== 32'hFFFFFFFC)
      $display("FAIL jal_imm got %h exp fffffffc", a_imm);
    else passes++;
    checks++;
    if (a_rd !== 5'd0 || a_illegal !== 1'b0 ||
        a_opc !== 7'h6F)
      $display("FAIL jal_fields got rd %0d ill %b opc %h",
               a_rd, a_illegal, a_opc);
    else passes++;
    checks++;
    if (w_imm !== 64'hFFFFFFFFFFFFFFFC)
      $display("FAIL jal_imm64 got %h exp fffffffffffffffc",
               w_imm);
    else passes++;
    tick;
    checks++;
    if (a_out_valid !== 1'b0)
      $display("FAIL jal_drain got %b exp 0", a_out_valid);
    else passes++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] wd [4];
    logic [31:0] ei [4];
    logic [2:0]  ef [4];
    logic [4:0]  er [4];
    wd = '{32'hFFF00093, 32'h123452B7,
           32'h0020A223, 32'h00000463};
    ei = '{32'hFFFFFFFF, 32'h12345000,
           32'h00000004, 32'h00000008};
    ef = '{3'(FMT_I), 3'(FMT_U), 3'(FMT_S), 3'(FMT_B)};
    er = '{5'd1, 5'd5, 5'd4, 5'd8};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_ins = wd[i];
      checks++;
      if (a_in_ready !== 1'b1)
        $display("FAIL b2b_ready%0d got %b exp 1",
                 i, a_in_ready);
      else passes++;
      tick;
      checks++;
      if (a_out_valid !== 1'b1 || a_imm !== ei[i] ||
          a_fmt !== ef[i] || a_rd !== er[i])
        $display("FAIL b2b_word%0d got v %b imm %h fmt %0d rd %0d exp 1 %h %0d %0d",
                 i, a_out_valid, a_imm, a_fmt, a_rd,
                 ei[i], ef[i], er[i]);
      else passes++;
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (a_out_valid !== 1'b0)
      $display("FAIL b2b_drain got %b exp 0", a_out_valid);
    else passes++;
  endtask

  task automatic test_formats;
    out_ready = 1'b1;
    in_valid = 1'b1; in_ins = 32'h0000007F;
    tick;
    in_valid = 1'b0;
    checks++;
    if (a_fmt !== FMT_NONE || a_illegal !== 1'b1 ||
        a_imm !== 32'h0)
      $display("FAIL illegal got fmt %0d ill %b imm %h exp %0d 1 0",
               a_fmt, a_illegal, a_imm, FMT_NONE);
    else passes++;
    tick;
    in_valid = 1'b1; in_ins = 32'h002081B3;
    tick;
    in_valid = 1'b0;
    checks++;
    if (a_fmt !== FMT_R || a_imm !== 32'h0 ||
        a_illegal !== 1'b0)
      $display("FAIL rtype got fmt %0d imm %h ill %b exp %0d 0 0",
               a_fmt, a_imm, a_illegal, FMT_R);
    else passes++;
    checks++;
    if (a_rd !== 5'd3 || a_rs1 !== 5'd1 ||
        a_rs2 !== 5'd2 || a_f3 !== 3'd0 || a_f7 !== 7'd0)
      $display("FAIL rfields got rd %0d rs1 %0d rs2 %0d exp 3 1 2",
               a_rd, a_rs1, a_rs2);
    else passes++;
    tick;
  endtask

  task automatic test_skid_stall;
    logic [31:0] wd [4];
    int idx, got, acc;
    logic fin;
    idx = 0; got = 0; acc = 0;
    for (int k = 0; k < 4; k++)
      wd[k] = (32'(k + 1) << 20) | (32'(k + 1) << 7) |
              32'h13;
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 3);
      in_valid = (idx < 4);
      if (idx < 4) in_ins = wd[idx];
      else in_ins = '0;
      fin = in_valid && a_in_ready;
      if (c == 1) begin
        checks++;
        if (a_in_ready !== 1'b1 || z_in_ready !== 1'b0)
          $display("FAIL stall_ready1 got %b/%b exp 1/0",
                   a_in_ready, z_in_ready);
        else passes++;
      end
      if (c == 2) begin
        checks++;
        if (a_in_ready !== 1'b0)
          $display("FAIL stall_full got %b exp 0", a_in_ready);
        else passes++;
      end
      if (a_out_valid && out_ready) begin
        checks++;
        if (got < 4 && a_imm === 32'(got + 1))
          passes++;
        else
          $display("FAIL stall_order got %h exp %h",
                   a_imm, 32'(got + 1));
        got++;
      end
      tick;
      if (fin) begin
        idx++;
        if (c < 3) acc++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc !== 2)
      $display("FAIL stall_accepts got %0d exp 2", acc);
    else passes++;
    checks++;
    if (got !== 4 || idx !== 4 || a_out_valid !== 1'b0)
      $display("FAIL stall_count got out %0d in %0d v %b exp 4 4 0",
               got, idx, a_out_valid);
    else passes++;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ins = (32'd5 << 20) | (32'd7 << 7) | 32'h13;
    tick;
    in_ins = (32'd6 << 20) | (32'd9 << 7) | 32'h13;
    tick;
    in_valid = 1'b0;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
      $display("FAIL pre_rst got rdy %b v %b exp 0 1",
               a_in_ready, a_out_valid);
    else passes++;
    rst = 1'b1;
    tick;
    checks++;
    if (a_out_valid !== 1'b0 || a_imm !== 32'h0 ||
        a_rd !== 5'd0 || a_opc !== 7'd0)
      $display("FAIL mid_rst got v %b imm %h rd %0d opc %h exp 0",
               a_out_valid, a_imm, a_rd, a_opc);
    else passes++;
    rst = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1)
      $display("FAIL mid_rst_ready got %b exp 1", a_in_ready);
    else passes++;
    out_ready = 1'b1;
    tick;
    checks++;
    if (a_out_valid !== 1'b0)
      $display("FAIL mid_rst_skid got %b exp 0", a_out_valid);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_jal();
    test_back_to_back();
    test_formats();
    test_skid_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
